// File: rtl/hcsr04_multi_interface.sv
// Round-robin controller for N_CH HC-SR04 ultrasonic sensors: trigger pulse,
// echo wait with timeout, echo width measurement, channel-tagged result.
module hcsr04_multi_interface #(
  parameter int N_CH           = 2,
  parameter int CNT_W          = 22,
  parameter int TRIG_CYCLES    = 500,
  parameter int TIMEOUT_CYCLES = 1_500_000,
  parameter int GAP_CYCLES     = 3_000_000,
  parameter int CH_W           = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             medir,
  input  logic             continuo,
  input  logic [N_CH-1:0]  echo,
  output logic [N_CH-1:0]  trigger,
  output logic [CNT_W-1:0] medida,
  output logic [CH_W-1:0]  canal,
  output logic             timeout,
  output logic             pronto,
  output logic             ocupado,
  output logic [3:0]       db_estado
);

  typedef enum logic [3:0] {
    S_INICIAL       = 4'h0,
    S_PREPARACAO    = 4'h1,
    S_ENVIA_TRIGGER = 4'h2,
    S_ESPERA_ECHO   = 4'h3,
    S_MEDIDA        = 4'h4,
    S_ARMAZENAMENTO = 4'h5,
    S_INTERVALO     = 4'h6,
    S_ERRO          = 4'hE,
    S_FINAL_MEDIDA  = 4'hF
  } state_t;

  localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
  localparam logic [CNT_W-1:0] TOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CH_W-1:0]  LAST_CH   = CH_W'(N_CH - 1);
  localparam logic [N_CH-1:0]  CH0_HOT   = N_CH'(1);

  state_t             r_state, w_next_state;
  logic [CNT_W-1:0]   r_cnt, w_cnt_next;
  logic [CH_W-1:0]    r_ch, w_ch_next;
  logic [N_CH-1:0]    r_echo_meta, r_echo_s;
  logic [CNT_W-1:0]   r_medida;
  logic [CH_W-1:0]    r_canal;
  logic               r_timeout;
  logic               w_echo, w_store_ok, w_store_err;

  assign w_echo = r_echo_s[r_ch];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_INICIAL;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    w_cnt_next   = r_cnt;
    w_ch_next    = r_ch;
    w_store_ok   = 1'b0;
    w_store_err  = 1'b0;
    case (r_state)
      S_INICIAL: begin
        if (medir || continuo) begin
          w_next_state = S_PREPARACAO;
          w_ch_next    = '0;
        end
      end
      S_PREPARACAO: begin
        w_next_state = S_ENVIA_TRIGGER;
        w_cnt_next   = '0;
      end
      S_ENVIA_TRIGGER: begin
        if (r_cnt == TRIG_LAST) begin
          w_next_state = S_ESPERA_ECHO;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_ESPERA_ECHO: begin
        // The cycle that first sees echo already counts as one cycle of width.
        if (w_echo) begin
          w_next_state = S_MEDIDA;
          w_cnt_next   = CNT_ONE;
        end else if (r_cnt == TOUT_LAST) begin
          w_next_state = S_ERRO;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_MEDIDA: begin
        if (!w_echo) w_next_state = S_ARMAZENAMENTO;
        else begin
          w_cnt_next = r_cnt + 1'b1;
          if (r_cnt == TOUT_LAST) w_next_state = S_ERRO;
        end
      end
      S_ARMAZENAMENTO: begin
        w_store_ok   = 1'b1;
        w_next_state = S_FINAL_MEDIDA;
      end
      S_ERRO: begin
        w_store_err  = 1'b1;
        w_next_state = S_FINAL_MEDIDA;
      end
      S_FINAL_MEDIDA: begin
        w_cnt_next = '0;
        if (r_ch != LAST_CH) begin
          w_ch_next    = r_ch + 1'b1;
          w_next_state = S_INTERVALO;
        end else if (continuo) begin
          w_ch_next    = '0;
          w_next_state = S_INTERVALO;
        end else begin
          w_next_state = S_INICIAL;
        end
      end
      S_INTERVALO: begin
        if (r_cnt == GAP_LAST) begin
          w_next_state = S_PREPARACAO;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      default: w_next_state = S_INICIAL;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_echo_meta <= '0;
      r_echo_s    <= '0;
      r_cnt       <= '0;
      r_ch        <= '0;
      r_medida    <= '0;
      r_canal     <= '0;
      r_timeout   <= 1'b0;
    end else begin
      r_echo_meta <= echo;
      r_echo_s    <= r_echo_meta;
      r_cnt       <= w_cnt_next;
      r_ch        <= w_ch_next;
      if (w_store_ok || w_store_err) begin
        r_medida  <= w_store_err ? {CNT_W{1'b1}} : r_cnt;
        r_canal   <= r_ch;
        r_timeout <= w_store_err;
      end
    end
  end

  // Decoded from the state register so reset clears them without a clock edge.
  assign trigger   = (r_state == S_ENVIA_TRIGGER) ? (CH0_HOT << r_ch) : '0;
  assign pronto    = (r_state == S_FINAL_MEDIDA);
  assign ocupado   = (r_state != S_INICIAL);
  assign db_estado = r_state;
  assign medida    = r_medida;
  assign canal     = r_canal;
  assign timeout   = r_timeout;

endmodule

// File: tb/tb_hcsr04_multi_interface.sv
// Randomised scoreboard bench for hcsr04_multi_interface: a sensor model answers
// each trigger with a planned echo, a monitor checks every stored result.
module tb_hcsr04_multi_interface;
  localparam int N_CH = 2, CNT_W = 8, TRIG_CYCLES = 4, TIMEOUT_CYCLES = 50, GAP_CYCLES = 8;
  localparam int CH_W = 1;
  localparam int RW = 1 + CH_W + CNT_W;
  localparam int P_IDLE = 0, P_TRIG = 1, P_DELAY = 2, P_HIGH = 3;

  logic clock = 1'b0, reset = 1'b0, medir = 1'b0, continuo = 1'b0;
  logic [N_CH-1:0]  echo = '0;
  logic [N_CH-1:0]  trigger;
  logic [CNT_W-1:0] medida;
  logic [CH_W-1:0]  canal;
  logic             timeout, pronto, ocupado;
  logic [3:0]       db_estado;

  int n_cmp = 0, n_err = 0;
  logic [RW-1:0] exp_q[$];
  int plan_d[N_CH][$];
  int plan_w[N_CH][$];
  int ph[N_CH], dly[N_CH], rem[N_CH], hi[N_CH];
  int cyc = 0, last_pronto = 0;
  bit noise_en = 1'b0;
  logic [3:0] prev_db = '0;

  always #5 clock = ~clock;

  hcsr04_multi_interface #(
    .N_CH(N_CH), .CNT_W(CNT_W), .TRIG_CYCLES(TRIG_CYCLES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .clock(clock), .reset(reset), .medir(medir), .continuo(continuo),
    .echo(echo), .trigger(trigger), .medida(medida), .canal(canal),
    .timeout(timeout), .pronto(pronto), .ocupado(ocupado), .db_estado(db_estado)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Echo raised d cycles after trigger falls reaches the FSM 2 cycles later
  // through the synchroniser; it must do so within the timeout window, and
  // a width of TIMEOUT_CYCLES or more is an over-range measurement.
  function automatic logic [RW-1:0] model(input int ch, input int d, input int w);
    if (d < 0 || d + 2 >= TIMEOUT_CYCLES || w >= TIMEOUT_CYCLES)
      return {1'b1, CH_W'(ch), {CNT_W{1'b1}}};
    return {1'b0, CH_W'(ch), CNT_W'(w)};
  endfunction

  task automatic plan(input int ch, input int d, input int w);
    plan_d[ch].push_back(d);
    plan_w[ch].push_back(w);
    exp_q.push_back(model(ch, d, w));
  endtask

  function automatic bit rsp_busy();
    for (int g = 0; g < N_CH; g++) if (ph[g] != P_IDLE) return 1'b1;
    return 1'b0;
  endfunction

  task automatic start_sweep();
    @(negedge clock) medir = 1'b1;
    repeat ($urandom_range(1, 2)) @(negedge clock);
    medir = 1'b0;
    repeat (6) @(negedge clock);
    medir = 1'b1;
    @(negedge clock) medir = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge clock);
      n++;
    end while ((exp_q.size() != 0 || ocupado || rsp_busy()) && n < budget);
    check(name, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_trig(input string name, input int g, input logic lvl, input int budget);
    int n = 0;
    while (trigger[g] !== lvl && n < budget) begin
      @(negedge clock);
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  // Sensor model: watches each trigger, then plays back the planned echo.
  initial begin
    for (int g = 0; g < N_CH; g++) ph[g] = P_IDLE;
    forever begin
      @(negedge clock);
      cyc++;
      if (pronto) last_pronto = cyc;
      for (int g = 0; g < N_CH; g++) begin
        if (!reset) begin
          ph[g] = P_IDLE;
          echo[g] = noise_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end else begin
          case (ph[g])
            P_IDLE: if (trigger[g]) begin
              ph[g] = P_TRIG;
              hi[g] = 1;
              if (g != 0) check("trig_gap", 32'(cyc - last_pronto), 32'(GAP_CYCLES + 2));
            end
            P_TRIG: if (trigger[g]) hi[g]++;
            else begin
              check("trig_width", 32'(hi[g]), 32'(TRIG_CYCLES));
              if (plan_d[g].size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unplanned_trigger: ch %0d triggered, no measurement expected", g);
                ph[g] = P_IDLE;
              end else begin
                dly[g] = plan_d[g].pop_front();
                rem[g] = plan_w[g].pop_front();
                if (dly[g] < 0) ph[g] = P_IDLE;
                else if (dly[g] == 0) begin
                  echo[g] = 1'b1;
                  ph[g] = P_HIGH;
                end else ph[g] = P_DELAY;
              end
            end
            P_DELAY: begin
              dly[g]--;
              if (dly[g] == 0) begin
                echo[g] = 1'b1;
                ph[g] = P_HIGH;
              end
            end
            P_HIGH: begin
              rem[g]--;
              if (rem[g] == 0) begin
                echo[g] = 1'b0;
                ph[g] = P_IDLE;
              end
            end
            default: ph[g] = P_IDLE;
          endcase
        end
      end
    end
  end

  // Monitor: every pronto pulse must match the oldest expected result.
  initial begin
    logic [RW-1:0] e;
    forever begin
      @(negedge clock);
      if (reset && pronto) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_pronto: canal %0d medida %0h timeout %0d", canal, medida, timeout);
        end else begin
          e = exp_q.pop_front();
          check("result", 32'({timeout, canal, medida}), 32'(e));
          check("db_before_final", 32'(prev_db), e[RW-1] ? 32'hE : 32'h5);
          check("db_final", 32'(db_estado), 32'hF);
          check("ocupado_busy", 32'(ocupado), 32'd1);
        end
      end
      prev_db = db_estado;
    end
  end

  initial begin
    int d, w;
    noise_en = 1'b1;
    repeat (6) @(negedge clock);
    check("reset_outputs", 32'({trigger, medida, canal, timeout, pronto, ocupado, db_estado}), 32'd0);
    noise_en = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    repeat (10) @(negedge clock);
    check("idle_state", 32'({ocupado, db_estado, trigger}), 32'd0);

    // Normal echo on ch0, no echo at all on ch1.
    plan(0, 3, 20);
    plan(1, -1, 0);
    start_sweep();
    wait_idle("sweep_a_done", 1000);
    check("idle_after_a", 32'({ocupado, db_estado}), 32'd0);

    // Echo stuck high past the timeout, still high during intervalo.
    plan(0, 2, 70);
    plan(1, 1, 5);
    start_sweep();
    wait_idle("sweep_b_done", 1000);

    // Boundaries of both timeout windows.
    plan(0, 47, 49);
    plan(1, 48, 3);
    start_sweep();
    wait_idle("sweep_c_done", 1000);
    plan(0, 0, 50);
    plan(1, 0, 1);
    start_sweep();
    wait_idle("sweep_d_done", 1000);

    repeat (6) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        d = ($urandom_range(0, 9) == 0) ? -1 : int'($urandom_range(0, 45));
        w = $urandom_range(1, 55);
        plan(ch, d, w);
      end
      start_sweep();
      wait_idle("sweep_rand_done", 1000);
    end

    // Continuous mode, dropped during the ch0 measurement of the third sweep.
    repeat (3) begin
      for (int ch = 0; ch < N_CH; ch++) begin
        d = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 40));
        w = $urandom_range(1, 40);
        plan(ch, d, w);
      end
    end
    @(negedge clock) continuo = 1'b1;
    begin
      int n = 0;
      while (exp_q.size() > 2 && n < 3000) begin
        @(negedge clock);
        n++;
      end
      check("cont_two_sweeps", 32'(n < 3000), 32'd1);
    end
    wait_trig("cont_trig0_rise", 0, 1'b1, 200);
    wait_trig("cont_trig0_fall", 0, 1'b0, 20);
    continuo = 1'b0;
    wait_idle("cont_done", 1000);
    check("idle_after_cont", 32'({ocupado, db_estado}), 32'd0);

    // Asynchronous reset in the middle of a trigger pulse.
    @(negedge clock) medir = 1'b1;
    @(negedge clock) medir = 1'b0;
    wait_trig("rst_trig_rise", 0, 1'b1, 50);
    @(negedge clock);
    #2 reset = 1'b0;
    #1 check("trig_async_drop", 32'({trigger, ocupado, db_estado}), 32'd0);
    repeat (5) @(negedge clock);
    check("no_pronto_in_reset", 32'({pronto, ocupado}), 32'd0);
    reset = 1'b1;
    repeat (5) @(negedge clock);
    plan(0, 5, 7);
    plan(1, 6, 9);
    start_sweep();
    wait_idle("sweep_after_reset", 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hcsr04_multi_interface.md
Name: hcsr04_multi_interface

Overview:
Parametrised successor to the single-sensor HC-SR04 control unit: a self-contained controller that drives N_CH ultrasonic sensors round-robin. It generates the trigger pulse, waits for echo with timeout, measures echo width in clock cycles, and stores the result tagged with channel number. It supports a one-shot sweep (medir) or continuous sweeping (continuo), and sits between the top-level sensor pins and the distance-conversion/display logic.

Parameters:
N_CH, 2, number of sensors (≥1); CH_W = max(1, clog2(N_CH)) derived
CNT_W, 22, width of cycle counter and medida; 2^CNT_W must exceed TIMEOUT_CYCLES
TRIG_CYCLES, 500, trigger pulse length in cycles (10 us @ 50 MHz)
TIMEOUT_CYCLES, 1_500_000, max cycles in espera_echo or in medida before error (30 ms)
GAP_CYCLES, 3_000_000, idle cycles between consecutive measurements (60 ms)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
medir  in  1  start one sweep over all channels (level, sampled only in inicial)
continuo  in  1  1 = sweep repeatedly
echo  in  N_CH  raw echo inputs, asynchronous
trigger  out  N_CH  trigger outputs, one-hot or zero
medida  out  CNT_W  last echo width in cycles; all-ones on timeout
canal  out  CH_W  channel of last stored result
timeout  out  1  last stored result was a timeout
pronto  out  1  one-cycle pulse per stored result
ocupado  out  1  1 in every state except inicial
db_estado  out  4  state code for 7-segment debug

Behaviour:
- reset=0 (async): state inicial; ch=0; cnt=0; trigger, medida, canal, timeout, pronto, ocupado = 0; db_estado=0; sync flops cleared.
- echo passes through a 2-FF synchroniser per channel (echo_s); only echo_s[ch] is used.
- States/db_estado: inicial 0, preparacao 1, envia_trigger 2, espera_echo 3, medida 4, armazenamento 5, intervalo 6, erro E, final_medida F; unused encodings -> inicial.
- inicial: if medir|continuo -> preparacao, with ch=0. Otherwise stay.
- preparacao: 1 cycle; cnt=0 -> envia_trigger.
- envia_trigger: trigger[ch]=1 for exactly TRIG_CYCLES cycles, then cnt=0 -> espera_echo.
- espera_echo: cnt++ each cycle. If echo_s[ch]=1 -> medida with cnt=1. Else if cnt==TIMEOUT_CYCLES-1 -> erro. Echo takes priority over timeout in the same cycle.
- medida: if echo_s[ch]=1, cnt++. If echo_s[ch]=0 -> armazenamento with cnt unchanged. Else if cnt==TIMEOUT_CYCLES-1 -> erro.
- Result: medida = exact number of cycles echo_s[ch] was high.
- armazenamento: medida<=cnt, canal<=ch, timeout<=0 -> final_medida.
- erro: medida<=all ones, canal<=ch, timeout<=1 -> final_medida.
- final_medida: pronto=1 for 1 cycle; the stored outputs are valid in this cycle and are held until the next store.
  - If ch<N_CH-1: ch++ -> intervalo.
  - Else if continuo: ch=0 -> intervalo.
  - Else -> inicial.
- intervalo: cnt counts GAP_CYCLES cycles, then cnt=0 -> preparacao.
- medir while ocupado: ignored. continuo dropped mid-sweep: the current sweep completes, then inicial.
- Latency: echo_s falling to pronto = 2 cycles (armazenamento, final_medida).
- N_CH=1: ch stays 0; canal is 1 bit, always 0.

Test Plan:
Benches use N_CH=2, CNT_W=8, TRIG_CYCLES=4, TIMEOUT_CYCLES=50, GAP_CYCLES=8.
1. reset=0 with echo toggling -> all outputs 0, db_estado=0; release reset, medir=0 -> remains inicial, ocupado=0.
2. medir=1 for 1 cycle; echo[0] high for 20 cycles after trigger[0] falls -> trigger[0] high exactly 4 cycles, pronto pulse with medida=20, canal=0, timeout=0; trigger[1] rises after 8-cycle intervalo plus preparacao.
3. Same sweep, echo[1] never rises -> 50 cycles in espera_echo, db_estado E then F, medida=8'hFF, canal=1, timeout=1; then inicial, ocupado=0.
4. echo[0] stuck high -> leaves medida via erro after cnt reaches 49, medida=8'hFF, timeout=1; echo[0] still high during intervalo causes no false result.
5. continuo=1 -> results canal 0,1,0,1...; continuo=0 during ch0 measurement -> ch1 result still produced, then inicial.
6. reset=0 asserted during envia_trigger -> trigger drops without waiting for a clock edge, pronto never pulses; a new medir after release starts at ch=0.
